irst_controller: RTL and testbench



---
 rtl/mips_16_defs.sv | 36 +++
 rtl/irst_mask_scan.sv | 23 ++
 rtl/irst_controller.sv | 118 +++++++++++
 tb/tb_irst_controller.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_16_defs.sv
// Shared definitions for the mips_16 core: irst command layout, modes, FSM states
// and the power-on scrub command also loaded into register 0 by register_file.
package mips_16_defs;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam int IRST_GO_BIT    = 15;
  localparam int IRST_MODE_LSB  = 12;
  localparam int IRST_MODE_W    = 3;
  localparam int IRST_DELAY_LSB = 8;
  localparam int IRST_DELAY_W   = 4;
  localparam int IRST_MASK_LSB  = 0;
  localparam int IRST_MASK_W    = 8;

  localparam logic [IRST_MODE_W-1:0] IRST_MODE_ZERO = 3'b000;
  localparam logic [IRST_MODE_W-1:0] IRST_MODE_ONES = 3'b001;
  localparam logic [IRST_MODE_W-1:0] IRST_MODE_IDX  = 3'b010;

  localparam logic [DATA_W-1:0] IRST_POR_CMD = 16'h8F0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DELAY,
    ST_WRITE,
    ST_DONE,
    ST_WAIT_CLR
  } irst_state_t;

  function automatic logic irst_mode_reserved(input logic [IRST_MODE_W-1:0] mode);
    return (mode != IRST_MODE_ZERO) && (mode != IRST_MODE_ONES) && (mode != IRST_MODE_IDX);
  endfunction

endpackage

// File: rtl/irst_mask_scan.sv
// Finds the lowest selected register index strictly above idx; last=1 when none is left.
module irst_mask_scan
  import mips_16_defs::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [ADDR_W-1:0]   idx,
  output logic [ADDR_W-1:0]   next_idx,
  output logic                last
);

  always_comb begin
    next_idx = '0;
    last     = 1'b1;
    // Descending walk so the lowest qualifying index is the one that sticks.
    for (int i = NUM_REGS - 1; i >= 1; i--) begin
      if (mask[i] && (ADDR_W'(i) > idx)) begin
        next_idx = ADDR_W'(i);
        last     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/irst_controller.sv
// Register-scrub sequencer driven by the irst command word held in register 0.
//
//   state    | meaning
//   IDLE     | waiting for GO
//   DECODE   | latch command fields, flag reserved MODE
//   DELAY    | settle down-count before writing
//   WRITE    | one scrub write per cycle to each selected register
//   DONE     | one-cycle irst_done pulse, register 0 gets cleared
//   WAIT_CLR | hold until GO reads back 0
module irst_controller
  import mips_16_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] irst_reg_data,
  output logic              irst_done,
  output logic              irst_stall,
  output logic              irst_wr_en,
  output logic [ADDR_W-1:0] irst_wr_dest,
  output logic [DATA_W-1:0] irst_wr_data,
  output logic              irst_err
);

  irst_state_t             state_q, state_d;
  logic [IRST_MODE_W-1:0]  mode_q;
  logic [NUM_REGS-1:0]     mask_q;
  logic [IRST_DELAY_W-1:0] cnt_q;
  logic [ADDR_W-1:0]       idx_q;
  logic                    err_q;
  logic                    stall_q;

  logic                    cmd_go;
  logic [IRST_MODE_W-1:0]  cmd_mode;
  logic [IRST_DELAY_W-1:0] cmd_delay;
  logic [NUM_REGS-1:0]     cmd_mask;
  logic [NUM_REGS-1:0]     scan_mask;
  logic [ADDR_W-1:0]       scan_next;
  logic                    scan_last;

  assign cmd_go    = irst_reg_data[IRST_GO_BIT];
  assign cmd_mode  = irst_reg_data[IRST_MODE_LSB +: IRST_MODE_W];
  assign cmd_delay = irst_reg_data[IRST_DELAY_LSB +: IRST_DELAY_W];
  assign cmd_mask  = {irst_reg_data[IRST_MASK_LSB+1 +: NUM_REGS-1], 1'b0};

  // DECODE scans the live word so a zero-delay command can enter WRITE at once.
  assign scan_mask = (state_q == ST_DECODE) ? cmd_mask : mask_q;

  irst_mask_scan u_scan (
    .mask     (scan_mask),
    .idx      (idx_q),
    .next_idx (scan_next),
    .last     (scan_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (cmd_go) state_d = ST_DECODE;
      ST_DECODE: begin
        if (irst_mode_reserved(cmd_mode))  state_d = ST_DONE;
        else if (cmd_delay != '0)          state_d = ST_DELAY;
        else                               state_d = scan_last ? ST_DONE : ST_WRITE;
      end
      ST_DELAY:    if (cnt_q == '0) state_d = scan_last ? ST_DONE : ST_WRITE;
      ST_WRITE:    if (scan_last) state_d = ST_DONE;
      ST_DONE:     state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!cmd_go) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered copy of (state != IDLE) so the stall line cannot glitch.
      stall_q <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE:   idx_q <= '0;
        ST_DECODE: begin
          mode_q <= cmd_mode;
          mask_q <= cmd_mask;
          cnt_q  <= cmd_delay - 1'b1;
          if (irst_mode_reserved(cmd_mode)) err_q <= 1'b1;
        end
        ST_DELAY:  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default:   ;
      endcase
      if (state_d == ST_WRITE) idx_q <= scan_next;
    end
  end

  always_comb begin
    irst_wr_en   = (state_q == ST_WRITE);
    irst_wr_dest = '0;
    irst_wr_data = '0;
    if (irst_wr_en) begin
      irst_wr_dest = idx_q;
      case (mode_q)
        IRST_MODE_ONES: irst_wr_data = '1;
        IRST_MODE_IDX:  irst_wr_data = DATA_W'(idx_q);
        default:        irst_wr_data = '0;
      endcase
    end
  end

  assign irst_done  = (state_q == ST_DONE);
  assign irst_stall = stall_q;
  assign irst_err   = err_q;

endmodule

// File: tb/tb_irst_controller.sv
// Directed bench for irst_controller: table of commands plus power-on, GO-hold and mid-write reset sequences.
module tb_irst_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irst_reg_data;
  logic        irst_done;
  logic        irst_stall;
  logic        irst_wr_en;
  logic [2:0]  irst_wr_dest;
  logic [15:0] irst_wr_data;
  logic        irst_err;

  int checks   = 0;
  int failures = 0;

  irst_controller dut (
    .clk           (clk),
    .rst           (rst),
    .irst_reg_data (irst_reg_data),
    .irst_done     (irst_done),
    .irst_stall    (irst_stall),
    .irst_wr_en    (irst_wr_en),
    .irst_wr_dest  (irst_wr_dest),
    .irst_wr_data  (irst_wr_data),
    .irst_err      (irst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  wmask;     // registers expected to be written
    int          kind;      // 0 zero, 1 all-ones, 2 index
    int          first_wr;  // cycle of first write, cycle 0 = IDLE sees GO
    int          done_cyc;
    logic        err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Follows one sequence from c1 to the cycle IDLE is expected again (done_cyc+2).
  task automatic run_seq(input string name, input logic [7:0] wmask, input int kind,
                         input int first_wr, input int done_cyc, input logic exp_err,
                         input bit auto_clr);
    logic [2:0]  dests[8];
    logic [15:0] exp_data;
    int nexp  = 0;
    int nwr   = 0;
    int ndone = 0;
    for (int i = 1; i < 8; i++)
      if (wmask[i]) begin
        dests[nexp] = 3'(i);
        nexp++;
      end
    for (int k = 1; k <= done_cyc + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, " stall"}, 32'(irst_stall), 32'(k <= done_cyc + 1));
      if (irst_wr_en) begin
        if (nwr < nexp) begin
          exp_data = (kind == 0) ? 16'h0000 : (kind == 1) ? 16'hFFFF : {13'b0, dests[nwr]};
          chk({name, " wr_cycle"}, 32'(k), 32'(first_wr + nwr));
          chk({name, " wr_dest"}, 32'(irst_wr_dest), 32'(dests[nwr]));
          chk({name, " wr_data"}, 32'(irst_wr_data), 32'(exp_data));
        end else begin
          chk({name, " extra_write"}, 32'(nwr + 1), 32'(nexp));
        end
        nwr++;
      end else begin
        chk({name, " idle_port"}, {13'b0, irst_wr_dest, irst_wr_data}, 32'h0);
      end
      if (irst_done) begin
        ndone++;
        chk({name, " done_cycle"}, 32'(k), 32'(done_cyc));
        if (auto_clr) irst_reg_data = 16'h0000;
      end
    end
    chk({name, " write_count"}, 32'(nwr), 32'(nexp));
    chk({name, " done_count"}, 32'(ndone), 32'd1);
    chk({name, " err"}, 32'(irst_err), 32'(exp_err));
  endtask

  initial begin
    vecs[0] = '{cmd: 16'h92FE, wmask: 8'hFE, kind: 1, first_wr: 4, done_cyc: 11, err: 1'b0};
    vecs[1] = '{cmd: 16'hA0A4, wmask: 8'hA4, kind: 2, first_wr: 2, done_cyc: 5,  err: 1'b0};
    vecs[2] = '{cmd: 16'h8301, wmask: 8'h00, kind: 0, first_wr: 0, done_cyc: 5,  err: 1'b0};
    vecs[3] = '{cmd: 16'hB000, wmask: 8'h00, kind: 0, first_wr: 0, done_cyc: 2,  err: 1'b1};

    // Power-on
    rst = 1'b1;
    irst_reg_data = 16'h8F0F;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {irst_done, irst_stall, irst_wr_en, irst_err, irst_wr_dest, irst_wr_data}, 32'h0);
    rst = 1'b0;
    run_seq("por", 8'h0E, 0, 17, 20, 1'b0, 1'b1);

    for (int v = 0; v < 4; v++) begin
      irst_reg_data = vecs[v].cmd;
      run_seq($sformatf("vec%0d", v), vecs[v].wmask, vecs[v].kind, vecs[v].first_wr,
              vecs[v].done_cyc, vecs[v].err, 1'b1);
    end

    // GO held high after done: must sit in WAIT_CLR with no second run
    irst_reg_data = 16'h8002;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) chk("hold wr_dest", 32'(irst_wr_en ? irst_wr_dest : 3'd0), 32'd1);
      if (k == 3) chk("hold done", 32'(irst_done), 32'd1);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold stall", 32'(irst_stall), 32'd1);
      chk("hold quiet", {30'b0, irst_done, irst_wr_en}, 32'h0);
    end
    irst_reg_data = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk("hold release", 32'(irst_stall), 32'd0);

    // Reset asserted right after the r3 write of 80FE
    irst_reg_data = 16'h80FE;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst r3", {irst_wr_en, irst_wr_dest}, {1'b1, 3'd3});
    rst = 1'b1;
    #1;
    chk("midrst outputs",
        {irst_done, irst_stall, irst_wr_en, irst_err, irst_wr_dest, irst_wr_data}, 32'h0);
    irst_reg_data = 16'h8F0F;
    @(negedge clk);
    rst = 1'b0;
    run_seq("por_rerun", 8'h0E, 0, 17, 20, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
